layer_input_collector: RTL and testbench

LAYER_INPUT_COLLECTOR -- requirements
Module: layer_input_collector

---
 rtl/ann_pkg.sv | 13 +
 rtl/collector_bank.sv | 41 ++++
 rtl/layer_input_collector.sv | 102 ++++++++++
 tb/tb_layer_input_collector.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ann_pkg.sv
// Shared types for the layer input collector: bank count, bank select and per-bank status.
package ann_pkg;
    localparam int NUM_BANKS = 2;
    localparam int IDX_W_MAX = 8;

    typedef logic [$clog2(NUM_BANKS)-1:0] bank_sel_t;

    // Index is stored at a fixed maximum width; the top uses the low $clog2(NEURON_WIDTH) bits.
    typedef struct packed {
        logic                 full;
        logic [IDX_W_MAX-1:0] wr_idx;
    } bank_status_t;
endpackage

// File: rtl/collector_bank.sv
// One ping-pong bank: NEURON_WIDTH sample lanes with per-lane write, zero-fill above the
// written lane, and a synchronous clear.
module collector_bank
    import ann_pkg::*;
#(
    parameter int LAYER_DATA_WIDTH = 8,
    parameter int NEURON_WIDTH     = 4,
    localparam int IDX_W           = (NEURON_WIDTH > 1) ? $clog2(NEURON_WIDTH) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wr_en_i,
    input  logic                               zero_fill_i,
    input  logic                               clr_i,
    input  logic [IDX_W-1:0]                   wr_lane_i,
    input  logic signed [LAYER_DATA_WIDTH-1:0] wr_data_i,
    output logic signed [LAYER_DATA_WIDTH-1:0] lanes_o [0:NEURON_WIDTH-1]
);

    logic signed [LAYER_DATA_WIDTH-1:0] lanes_q [0:NEURON_WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < NEURON_WIDTH; l++) lanes_q[l] <= '0;
        end else begin
            for (int l = 0; l < NEURON_WIDTH; l++) begin
                if (clr_i) begin
                    lanes_q[l] <= '0;
                end else if (wr_en_i) begin
                    if (IDX_W'(l) == wr_lane_i)
                        lanes_q[l] <= wr_data_i;
                    else if (zero_fill_i && (IDX_W'(l) > wr_lane_i))
                        lanes_q[l] <= '0;
                end
            end
        end
    end

    assign lanes_o = lanes_q;

endmodule

// File: rtl/layer_input_collector.sv
// Assembles a stream of signed samples into NEURON_WIDTH-wide vectors using two ping-pong
// banks, so one bank fills while the other is presented downstream.
module layer_input_collector
    import ann_pkg::*;
#(
    parameter int LAYER_DATA_WIDTH = 8,
    parameter int NEURON_WIDTH     = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic signed [LAYER_DATA_WIDTH-1:0] in_data,
    input  logic                               in_last,
    output logic signed [LAYER_DATA_WIDTH-1:0] data_out [0:NEURON_WIDTH-1],
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               frame_err,
    input  logic                               err_clr
);

    localparam int IDX_W = (NEURON_WIDTH > 1) ? $clog2(NEURON_WIDTH) : 1;
    localparam logic [IDX_W_MAX-1:0] LAST_IDX = IDX_W_MAX'(NEURON_WIDTH - 1);

    bank_status_t st_q [NUM_BANKS];
    bank_status_t st_d [NUM_BANKS];
    bank_sel_t    wr_bank_q, wr_bank_d;
    bank_sel_t    rd_bank_q, rd_bank_d;
    logic         frame_err_q, frame_err_d;

    logic xfer, cons, at_end, close;
    logic signed [LAYER_DATA_WIDTH-1:0] bank_lanes [NUM_BANKS][NEURON_WIDTH];

    assign in_ready  = !st_q[wr_bank_q].full;
    assign out_valid = st_q[rd_bank_q].full;
    assign frame_err = frame_err_q;

    assign xfer   = in_valid && in_ready;
    assign cons   = out_valid && out_ready;
    assign at_end = (st_q[wr_bank_q].wr_idx == LAST_IDX);
    assign close  = xfer && (in_last || at_end);

    always_comb begin
        st_d        = st_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        frame_err_d = frame_err_q;
        if (xfer) begin
            if (close) begin
                st_d[wr_bank_q].full   = 1'b1;
                st_d[wr_bank_q].wr_idx = '0;
                wr_bank_d              = ~wr_bank_q;
            end else begin
                st_d[wr_bank_q].wr_idx = st_q[wr_bank_q].wr_idx + IDX_W_MAX'(1);
            end
        end
        // A consume only ever targets a full bank, which cannot be the bank being written.
        if (cons) begin
            st_d[rd_bank_q].full = 1'b0;
            rd_bank_d            = ~rd_bank_q;
        end
        if (xfer && at_end && !in_last)
            frame_err_d = 1'b1;
        else if (err_clr)
            frame_err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++) st_q[b] <= '0;
            wr_bank_q   <= '0;
            rd_bank_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            st_q        <= st_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            frame_err_q <= frame_err_d;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        collector_bank #(
            .LAYER_DATA_WIDTH(LAYER_DATA_WIDTH),
            .NEURON_WIDTH    (NEURON_WIDTH)
        ) u_bank (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_en_i    (xfer && (wr_bank_q == bank_sel_t'(b))),
            .zero_fill_i(in_last),
            .clr_i      (cons && (rd_bank_q == bank_sel_t'(b))),
            .wr_lane_i  (st_q[wr_bank_q].wr_idx[IDX_W-1:0]),
            .wr_data_i  (in_data),
            .lanes_o    (bank_lanes[b])
        );
    end

    always_comb begin
        for (int l = 0; l < NEURON_WIDTH; l++) data_out[l] = bank_lanes[rd_bank_q][l];
    end

endmodule

// File: tb/tb_layer_input_collector.sv
// Scoreboard bench: a sample-level model predicts closed vectors, occupancy and frame_err;
// a negedge monitor compares the DUT against it every cycle.
module tb_layer_input_collector;
    localparam int W = 8;
    localparam int N = 4;

    typedef logic signed [W-1:0] vec_t [N];

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] in_data = '0;
    logic                in_last = 1'b0;
    logic signed [W-1:0] data_out [0:N-1];
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic                frame_err;
    logic                err_clr = 1'b0;

    int     n_vec = 0;
    int     n_bad = 0;
    int     n_cons = 0;
    vec_t   exp_q[$];
    int     part[$];
    logic   exp_ferr = 1'b0;

    layer_input_collector #(.LAYER_DATA_WIDTH(W), .NEURON_WIDTH(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .data_out (data_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .frame_err(frame_err),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare, then advance the model by what happens at the coming posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            part.delete();
            exp_ferr = 1'b0;
            check("reset_out_valid", int'(out_valid), 0);
            check("reset_frame_err", int'(frame_err), 0);
            for (int i = 0; i < N; i++) check("reset_data_out", int'(data_out[i]), 0);
        end else begin
            automatic bit xf = in_valid && (exp_q.size() < 2);
            automatic bit cs = out_ready && (exp_q.size() > 0);
            check("out_valid", int'(out_valid), int'(exp_q.size() > 0));
            check("in_ready", int'(in_ready), int'(exp_q.size() < 2));
            check("frame_err", int'(frame_err), int'(exp_ferr));
            if (out_valid && exp_q.size() > 0)
                for (int i = 0; i < N; i++) check($sformatf("data_out[%0d]", i), int'(data_out[i]), int'(exp_q[0][i]));
            if (xf && part.size() == N - 1 && !in_last) exp_ferr = 1'b1;
            else if (err_clr) exp_ferr = 1'b0;
            if (cs) begin
                void'(exp_q.pop_front());
                n_cons++;
            end
            if (xf) begin
                part.push_back(int'(in_data));
                if (in_last || part.size() == N) begin
                    automatic vec_t v;
                    for (int i = 0; i < N; i++) v[i] = (i < part.size()) ? W'(part[i]) : '0;
                    exp_q.push_back(v);
                    part.delete();
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and hold it until it is accepted (bounded).
    task automatic send(input int v, input bit last);
        bit ok;
        in_valid = 1'b1;
        in_data  = W'(v);
        in_last  = last;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            ok = in_ready;
            step();
            if (ok) return;
        end
        check("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        int c0;
        repeat (2) step();
        rst_n = 1'b1;
        step();

        out_ready = 1'b1;
        send(1, 0); send(2, 0); send(3, 0); send(4, 1);
        idle(3);
        send(-5, 0); send(7, 1);
        idle(3);

        out_ready = 1'b0;
        fork
            for (int i = 0; i < 12; i++) send(10 + i, (i % 4) == 3);
            begin
                repeat (14) step();
                out_ready = 1'b1;
                step();
                out_ready = 1'b0;
            end
        join
        idle(2);
        out_ready = 1'b1;
        idle(6);

        for (int i = 0; i < 4; i++) send(9, 0);
        idle(3);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        idle(2);

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(20 + i, i == 3);
        send(30, 0); send(31, 0);
        idle(1);
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        send(4, 0); send(3, 0); send(2, 0); send(1, 1);
        idle(3);

        c0 = n_cons;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            in_last  = (i % 4) == 3;
            step();
        end
        idle(3);
        check("stream_vectors", n_cons - c0, 5);

        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = W'($urandom);
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            err_clr   = ($urandom_range(0, 7) == 0);
            step();
        end
        err_clr   = 1'b0;
        out_ready = 1'b1;
        idle(6);
        check("drain_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
